// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states
// and the width of the wait-state counter.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } accessSize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmemState_t;

  // Wait-state counter width; holds 0..15.
  localparam int WAIT_WIDTH = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: merges sub-word store data into the old
// word, produces byte enables, extends sub-word loads and flags misalignment.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic [31:0] oldWord,
  input  logic [31:0] storeData,
  output logic [31:0] mergedWord,
  output logic [3:0]  byteEnable,
  output logic [31:0] loadValue,
  output logic        misalign
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;
  logic [31:0] replData;

  assign selByte = oldWord[{lane, 3'b000} +: 8];
  assign selHalf = oldWord[{lane[1], 4'b0000} +: 16];

  // Decode size into enables, replicated store data, load extension and alignment
  always_comb begin
    byteEnable = 4'b0000;
    replData   = storeData;
    loadValue  = 32'h0;
    misalign   = 1'b0;
    case (size)
      SIZE_BYTE: begin
        byteEnable = 4'b0001 << lane;
        replData   = {4{storeData[7:0]}};
        loadValue  = unsignedLoad ? {24'h0, selByte} : {{24{selByte[7]}}, selByte};
      end
      SIZE_HALF: begin
        byteEnable = lane[1] ? 4'b1100 : 4'b0011;
        replData   = {2{storeData[15:0]}};
        loadValue  = unsignedLoad ? {16'h0, selHalf} : {{16{selHalf[15]}}, selHalf};
        misalign   = lane[0];
      end
      SIZE_WORD: begin
        byteEnable = 4'b1111;
        loadValue  = oldWord;
        misalign   = (lane != 2'b00);
      end
      default: begin
        byteEnable = 4'b0000;
      end
    endcase
  end

  // Each byte of the result comes from the replicated store data when enabled
  for (genvar gi = 0; gi < 4; gi++) begin : gLaneMerge
    assign mergedWord[8*gi +: 8] = byteEnable[gi] ? replData[8*gi +: 8] : oldWord[8*gi +: 8];
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte/halfword/word data memory with req/ready handshake, configurable
// wait states and fault reporting. The old word is read when the access is
// accepted so the store merge and load extension work from a registered read.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        fault,
  output logic        busy
);

  localparam int ADDR_BITS = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  dmemState_t            stateReg;
  logic [WAIT_WIDTH-1:0] countReg;
  logic                  memWriteReg;
  logic [1:0]            sizeReg;
  logic                  unsignedReg;
  logic [1:0]            laneReg;
  logic [ADDR_BITS-1:0]  indexReg;
  logic [31:0]           writeDataReg;
  logic                  outOfRangeReg;
  logic [31:0]           oldWordReg;
  logic [31:0]           readDataReg;
  logic                  readyReg;
  logic                  faultReg;
  logic                  busyReg;

  logic                  accept;
  logic                  complete;
  logic                  accessFault;
  logic [31:0]           mergedWord;
  logic [3:0]            byteEnable;
  logic [31:0]           loadValue;
  logic                  misalign;

  assign accept      = req && (stateReg == IDLE || stateReg == DONE);
  assign complete    = (stateReg == WAIT) && (countReg == '0);
  assign accessFault = outOfRangeReg || (sizeReg == SIZE_ILLEGAL) || misalign;

  dmem_lane_align uLaneAlign (
    .lane         (laneReg),
    .size         (sizeReg),
    .unsignedLoad (unsignedReg),
    .oldWord      (oldWordReg),
    .storeData    (writeDataReg),
    .mergedWord   (mergedWord),
    .byteEnable   (byteEnable),
    .loadValue    (loadValue),
    .misalign     (misalign)
  );

  // Handshake FSM: latch the request, count wait states, then complete
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      countReg    <= '0;
      readyReg    <= 1'b0;
      faultReg    <= 1'b0;
      busyReg     <= 1'b0;
      readDataReg <= 32'h0;
    end else begin
      readyReg <= 1'b0;
      case (stateReg)
        IDLE, DONE: begin
          if (req) begin
            memWriteReg   <= memWrite;
            sizeReg       <= size;
            unsignedReg   <= unsignedLoad;
            laneReg       <= address[1:0];
            indexReg      <= address[ADDR_BITS+1:2];
            writeDataReg  <= writeData;
            outOfRangeReg <= (address[31:2] >= 30'(DEPTH_WORDS));
            countReg      <= WAIT_WIDTH'(WAIT_STATES);
            stateReg      <= WAIT;
            busyReg       <= 1'b1;
          end else if (stateReg == DONE) begin
            stateReg <= IDLE;
          end
        end
        WAIT: begin
          if (countReg != '0) begin
            countReg <= countReg - 1'b1;
          end else begin
            stateReg <= DONE;
            busyReg  <= 1'b0;
            readyReg <= 1'b1;
            faultReg <= accessFault;
            if (accessFault) begin
              readDataReg <= 32'h0;
            end else if (!memWriteReg) begin
              readDataReg <= loadValue;
            end
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Word array: registered read on acceptance, merged write on completion
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      oldWordReg <= mem[address[ADDR_BITS+1:2]];
    end
    if (!reset && complete && memWriteReg && !accessFault) begin
      mem[indexReg] <= mergedWord;
    end
  end

  assign readData = readDataReg;
  assign ready    = readyReg;
  assign fault    = faultReg;
  assign busy     = busyReg;

endmodule
